// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter that merges N_REQ valid/ready streams into one registered output stream.
// A grant lasts for a whole packet, or until MAX_BURST beats have passed, whichever comes first.
module axi_rr_arbiter #(
  parameter  int N_REQ     = 4,
  parameter  int WIDTH     = 64,
  parameter  int MAX_BURST = 8,
  localparam int IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       vld_in,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  input  logic [N_REQ-1:0]       last_in,
  output logic [N_REQ-1:0]       rdy_in,
  output logic                   vld_out,
  output logic [WIDTH-1:0]       data_out,
  output logic                   last_out,
  output logic [IDW-1:0]         id_out,
  input  logic                   rdy_out
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
  logic             vld_out_q, vld_out_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             last_out_q, last_out_d;
  logic [IDW-1:0]   id_out_q, id_out_d;

  logic             pick_found;
  logic [IDW-1:0]   pick_idx;
  logic             accept;
  logic             last_next;
  logic [WIDTH-1:0] sel_data;

  // The first valid requester at or after ptr, wrapping around modulo N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!pick_found && vld_in[idx]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    rdy_in = '0;
    if (state_q == LOCKED) begin
      rdy_in[grant_q] = !vld_out_q || rdy_out;
    end
  end

  assign accept    = (state_q == LOCKED) && vld_in[grant_q] && rdy_in[grant_q];
  assign sel_data  = data_in[grant_q*WIDTH +: WIDTH];
  assign last_next = last_in[grant_q] || (beat_cnt_q == CW'(MAX_BURST - 1));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    vld_out_d  = vld_out_q;
    data_out_d = data_out_q;
    last_out_d = last_out_q;
    id_out_d   = id_out_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        if (accept) begin
          data_out_d = sel_data;
          id_out_d   = grant_q;
          vld_out_d  = 1'b1;
          last_out_d = last_next;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_next) begin
            state_d    = IDLE;
            ptr_d      = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
            beat_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Drain without a replacement beat; a stalled beat keeps its defaults.
    if (vld_out_q && rdy_out && !accept) begin
      vld_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      vld_out_q  <= 1'b0;
      data_out_q <= '0;
      last_out_q <= 1'b0;
      id_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      vld_out_q  <= vld_out_d;
      data_out_q <= data_out_d;
      last_out_q <= last_out_d;
      id_out_q   <= id_out_d;
    end
  end

  assign vld_out  = vld_out_q;
  assign data_out = data_out_q;
  assign last_out = last_out_q;
  assign id_out   = id_out_q;

endmodule
